// File: rtl/mult_product_accumulator.sv
// Sums a programmed batch of signed products into a guard-bit accumulator and
// presents one saturated result per batch over a valid/ready output port.
module mult_product_accumulator #(
  parameter int PW    = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] batch_len,
  output logic             busy,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic [PW-1:0]    prod_data,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [PW-1:0]    acc_data,
  output logic             acc_sat,
  output logic [CNT_W-1:0] acc_count
);

  localparam int AW = PW + CNT_W;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_reg, state_next;
  logic [AW-1:0]    acc_reg, acc_next;
  logic [CNT_W-1:0] count_reg, len_reg;
  logic             prod_hs, last_hs, out_hs, overflow;
  logic [CNT_W-1:0] guard_diff;
  logic [PW-1:0]    sat_value;

  assign busy       = (state_reg != ST_IDLE);
  assign prod_ready = (state_reg == ST_ACCUM);
  assign acc_valid  = (state_reg == ST_OUT);

  assign prod_hs = prod_valid & prod_ready;
  assign last_hs = prod_hs & (count_reg == (len_reg - CNT_ONE));
  assign out_hs  = acc_valid & acc_ready;

  assign acc_next = acc_reg + {{CNT_W{prod_data[PW-1]}}, prod_data};

  // The sum fits in PW bits only if every guard bit matches the PW-bit sign bit.
  generate
    for (genvar gi = 0; gi < CNT_W; gi++) begin : g_guard
      assign guard_diff[gi] = acc_next[PW+gi] ^ acc_next[PW-1];
    end
  endgenerate

  assign overflow  = |guard_diff;
  assign sat_value = acc_next[AW-1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = (batch_len == '0) ? ST_OUT : ST_ACCUM;
      end
      ST_ACCUM: begin
        if (last_hs) state_next = ST_OUT;
      end
      ST_OUT: begin
        if (out_hs) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      acc_reg   <= '0;
      count_reg <= '0;
      len_reg   <= '0;
      acc_data  <= '0;
      acc_sat   <= 1'b0;
      acc_count <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            len_reg   <= batch_len;
            acc_reg   <= '0;
            count_reg <= '0;
            if (batch_len == '0) begin
              acc_data  <= '0;
              acc_sat   <= 1'b0;
              acc_count <= '0;
            end
          end
        end
        ST_ACCUM: begin
          if (prod_hs) begin
            acc_reg   <= acc_next;
            count_reg <= count_reg + CNT_ONE;
          end
          // Result registers are loaded on the same edge that enters OUT.
          if (last_hs) begin
            acc_data  <= overflow ? sat_value : acc_next[PW-1:0];
            acc_sat   <= overflow;
            acc_count <= count_reg + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Bench for mult_product_accumulator: directed scenarios plus randomized batches
// checked against an arithmetic sum-and-clip reference model.
module tb_mult_product_accumulator;

  logic        clk = 1'b0;
  logic        reset, start, prod_valid, acc_ready;
  logic [15:0] batch_len;
  logic [63:0] prod_data;
  logic        busy, prod_ready, acc_valid, acc_sat;
  logic [63:0] acc_data;
  logic [15:0] acc_count;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic signed [79:0] MAXV = 80'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [79:0] MINV = -80'sh8000_0000_0000_0000;

  always #5 clk = ~clk;

  mult_product_accumulator dut (
    .clk(clk), .reset(reset), .start(start), .batch_len(batch_len), .busy(busy),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .prod_data(prod_data),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
    .acc_sat(acc_sat), .acc_count(acc_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer sum of the batch, then clip to the signed 64-bit range.
  function automatic void model(input logic [63:0] prods[$], output logic [63:0] d,
                                output logic s);
    logic signed [79:0] sum;
    longint p;
    sum = '0;
    foreach (prods[i]) begin
      p = prods[i];
      sum = sum + p;
    end
    if (sum > MAXV) begin d = 64'h7FFF_FFFF_FFFF_FFFF; s = 1'b1; end
    else if (sum < MINV) begin d = 64'h8000_0000_0000_0000; s = 1'b1; end
    else begin d = sum[63:0]; s = 1'b0; end
  endfunction

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; batch_len = '0; prod_valid = 1'b0;
    prod_data = '0; acc_ready = 1'b0;
    repeat (3) tick;
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (prod_ready !== 1'b0) begin n_err++; $display("FAIL reset_prod_ready got=%b exp=0", prod_ready); end
    n_cmp++; if (acc_valid !== 1'b0) begin n_err++; $display("FAIL reset_acc_valid got=%b exp=0", acc_valid); end
    n_cmp++; if (acc_data !== 64'd0) begin n_err++; $display("FAIL reset_acc_data got=%h exp=0", acc_data); end
    $display("reset: done");
  endtask

  task automatic test_basic;
    logic [63:0] p [3];
    p[0] = 64'd5; p[1] = -64'sd2; p[2] = 64'd10;
    start = 1'b1; batch_len = 16'd3; tick; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      prod_valid = 1'b1; prod_data = p[i];
      n_cmp++; if (prod_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready[%0d] got=%b exp=1", i, prod_ready); end
      n_cmp++; if (acc_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid[%0d] got=%b exp=0", i, acc_valid); end
      tick;
    end
    prod_valid = 1'b0;
    n_cmp++; if (acc_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%b exp=1", acc_valid); end
    n_cmp++; if (acc_data !== 64'd13) begin n_err++; $display("FAIL basic_data got=%0d exp=13", $signed(acc_data)); end
    n_cmp++; if (acc_count !== 16'd3) begin n_err++; $display("FAIL basic_count got=%0d exp=3", acc_count); end
    n_cmp++; if (acc_sat !== 1'b0) begin n_err++; $display("FAIL basic_sat got=%b exp=0", acc_sat); end
    acc_ready = 1'b1; tick; acc_ready = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle got=%b exp=0", busy); end
    $display("basic: batch of 3 -> %0d", $signed(acc_data));
  endtask

  task automatic test_saturation;
    logic [63:0] v [2];
    v[0] = 64'h7FFF_FFFF_FFFF_FFFF; v[1] = 64'h8000_0000_0000_0000;
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; batch_len = 16'd2; tick; start = 1'b0;
      prod_valid = 1'b1; prod_data = v[k];
      repeat (2) tick;
      prod_valid = 1'b0;
      n_cmp++; if (acc_valid !== 1'b1) begin n_err++; $display("FAIL sat_valid[%0d] got=%b exp=1", k, acc_valid); end
      n_cmp++; if (acc_data !== v[k]) begin n_err++; $display("FAIL sat_data[%0d] got=%h exp=%h", k, acc_data, v[k]); end
      n_cmp++; if (acc_sat !== 1'b1) begin n_err++; $display("FAIL sat_flag[%0d] got=%b exp=1", k, acc_sat); end
      acc_ready = 1'b1; tick; acc_ready = 1'b0;
      $display("saturation: 2 x %h -> %h sat=%b", v[k], acc_data, acc_sat);
    end
  endtask

  task automatic test_zero_len;
    prod_valid = 1'b1; prod_data = 64'd99;
    start = 1'b1; batch_len = 16'd0; tick; start = 1'b0;
    n_cmp++; if (acc_valid !== 1'b1) begin n_err++; $display("FAIL zero_valid got=%b exp=1", acc_valid); end
    n_cmp++; if (prod_ready !== 1'b0) begin n_err++; $display("FAIL zero_prod_ready got=%b exp=0", prod_ready); end
    n_cmp++; if (acc_data !== 64'd0) begin n_err++; $display("FAIL zero_data got=%h exp=0", acc_data); end
    n_cmp++; if (acc_count !== 16'd0) begin n_err++; $display("FAIL zero_count got=%0d exp=0", acc_count); end
    n_cmp++; if (acc_sat !== 1'b0) begin n_err++; $display("FAIL zero_sat got=%b exp=0", acc_sat); end
    acc_ready = 1'b1; tick; acc_ready = 1'b0; prod_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_idle got=%b exp=0", busy); end
    $display("zero_len: empty batch -> 0");
  endtask

  task automatic test_bubbles_backpressure;
    bit pat [7];
    int idx;
    pat = '{1, 0, 0, 1, 1, 0, 1};
    idx = 0;
    start = 1'b1; batch_len = 16'd4; tick; start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      prod_valid = pat[c];
      prod_data  = pat[c] ? 64'(idx + 1) : 64'hDEAD;
      tick;
      if (pat[c]) idx++;
    end
    prod_valid = 1'b0;
    n_cmp++; if (acc_valid !== 1'b1) begin n_err++; $display("FAIL bub_valid got=%b exp=1", acc_valid); end
    for (int c = 0; c < 5; c++) begin
      start = c[0]; prod_valid = 1'b1; prod_data = 64'd1000;
      tick;
      n_cmp++; if (acc_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d] got=%b exp=1", c, acc_valid); end
      n_cmp++; if (acc_data !== 64'd10) begin n_err++; $display("FAIL hold_data[%0d] got=%0d exp=10", c, acc_data); end
      n_cmp++; if (acc_count !== 16'd4) begin n_err++; $display("FAIL hold_count[%0d] got=%0d exp=4", c, acc_count); end
      n_cmp++; if (prod_ready !== 1'b0) begin n_err++; $display("FAIL hold_prod_ready[%0d] got=%b exp=0", c, prod_ready); end
    end
    prod_valid = 1'b0;
    // start coincident with the output handshake must not open a new batch
    start = 1'b1; acc_ready = 1'b1; tick; start = 1'b0; acc_ready = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bub_start_ignored got=%b exp=0", busy); end
    tick;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bub_still_idle got=%b exp=0", busy); end
    $display("bubbles: batch of 4 with bubbles and backpressure -> %0d", acc_data);
  endtask

  task automatic test_reset_mid_batch;
    start = 1'b1; batch_len = 16'd3; tick; start = 1'b0;
    prod_valid = 1'b1; prod_data = 64'd50; tick; prod_valid = 1'b0;
    reset = 1'b1; tick; reset = 1'b0;
    n_cmp++; if ({busy, prod_ready, acc_valid, acc_sat} !== 4'b0) begin n_err++;
      $display("FAIL midrst_flags got=%b exp=0000", {busy, prod_ready, acc_valid, acc_sat}); end
    n_cmp++; if (acc_data !== 64'd0) begin n_err++; $display("FAIL midrst_data got=%h exp=0", acc_data); end
    n_cmp++; if (acc_count !== 16'd0) begin n_err++; $display("FAIL midrst_count got=%0d exp=0", acc_count); end
    start = 1'b1; batch_len = 16'd1; tick; start = 1'b0;
    prod_valid = 1'b1; prod_data = -64'sd7; tick; prod_valid = 1'b0;
    n_cmp++; if (acc_valid !== 1'b1) begin n_err++; $display("FAIL midrst_valid got=%b exp=1", acc_valid); end
    n_cmp++; if (acc_data !== -64'sd7) begin n_err++; $display("FAIL midrst_new_data got=%0d exp=-7", $signed(acc_data)); end
    n_cmp++; if (acc_count !== 16'd1) begin n_err++; $display("FAIL midrst_new_count got=%0d exp=1", acc_count); end
    acc_ready = 1'b1; tick; acc_ready = 1'b0;
    $display("reset_mid_batch: new batch -> %0d", $signed(acc_data));
  endtask

  task automatic test_random;
    logic [63:0] prods[$];
    logic [63:0] exp_d, v;
    logic        exp_s;
    int len, idx, guard, hold;
    bit hs;
    for (int b = 0; b < 30; b++) begin
      len = $urandom_range(0, 8);
      prods = {};
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 3))
          0: v = 64'($signed($urandom_range(0, 2000)) - 1000);
          1: v = 64'h7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 50));
          2: v = 64'h8000_0000_0000_0000 + 64'($urandom_range(0, 50));
          default: v = {$urandom, $urandom};
        endcase
        prods.push_back(v);
      end
      model(prods, exp_d, exp_s);
      start = 1'b1; batch_len = 16'(len); tick; start = 1'b0;
      idx = 0; guard = 0;
      while (idx < len && guard < 200) begin
        prod_valid = ($urandom_range(0, 3) != 0);
        prod_data  = prod_valid ? prods[idx] : {$urandom, $urandom};
        hs = prod_valid && prod_ready;
        tick;
        if (hs) idx++;
        guard++;
      end
      prod_valid = 1'b0;
      n_cmp++; if (idx != len) begin n_err++; $display("FAIL rnd_feed[%0d] got=%0d exp=%0d", b, idx, len); end
      n_cmp++; if (acc_valid !== 1'b1) begin n_err++; $display("FAIL rnd_valid[%0d] got=%b exp=1", b, acc_valid); end
      hold = $urandom_range(0, 3);
      for (int h = 0; h <= hold; h++) begin
        n_cmp++; if (acc_data !== exp_d) begin n_err++; $display("FAIL rnd_data[%0d] got=%h exp=%h", b, acc_data, exp_d); end
        n_cmp++; if (acc_sat !== exp_s) begin n_err++; $display("FAIL rnd_sat[%0d] got=%b exp=%b", b, acc_sat, exp_s); end
        n_cmp++; if (acc_count !== 16'(len)) begin n_err++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", b, acc_count, len); end
        acc_ready = (h == hold);
        tick;
      end
      acc_ready = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rnd_idle[%0d] got=%b exp=0", b, busy); end
      $display("random batch %0d: len=%0d result=%h sat=%b", b, len, exp_d, exp_s);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_basic;
    test_saturation;
    test_zero_len;
    test_bubbles_backpressure;
    test_reset_mid_batch;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
